// File: rtl/pipe_pkg.sv
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types for the pipeline stage registers: handshake
//                state encoding and the default MEM/WB payload bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic        WriteReg;
        logic        data_mux;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [15:0] ALU_res;
        logic [15:0] data_mem;
    } mem_wb_payload_t;

    localparam int MEM_WB_W = $bits(mem_wb_payload_t);

endpackage

`default_nettype wire

// File: rtl/sat_cnt.sv
// ============================================================================
//  Module      : sat_cnt
//  Description : Saturating up-counter, synchronous increment, asynchronous
//                active-low reset. Sticks at all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ============================================================================
//  Module      : pipe_stage_skid
//  Description : Valid/ready pipeline stage with a 2-entry skid buffer and an
//                opaque payload. in_ready is a pure function of local state.
//                Optional statistics counters under PIPE_STAGE_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = MEM_WB_W,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]     stat_stall_cnt,
    output logic [CNT_W-1:0]     stat_flush_cnt
`endif
);

    localparam logic [1:0] c_ST_EMPTY = EMPTY;
    localparam logic [1:0] c_ST_BUSY  = BUSY;
    localparam logic [1:0] c_ST_FULL  = FULL;

    logic [1:0]           r_state;
    logic [PAYLOAD_W-1:0] r_main_q;
    logic [PAYLOAD_W-1:0] r_skid_q;
    logic                 w_acc_in;
    logic                 w_acc_out;

    assign out_valid = (r_state != c_ST_EMPTY);
    assign in_ready  = (r_state != c_ST_FULL);
    assign out_data  = r_main_q;

    assign w_acc_in  = in_valid & in_ready;
    assign w_acc_out = out_valid & out_ready;

    // Flush only forces the state; stale data in the registers is never
    // observable because out_valid drops with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_EMPTY;
            r_main_q <= '0;
            r_skid_q <= '0;
        end else if (flush) begin
            r_state <= c_ST_EMPTY;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_acc_in) begin
                        r_state  <= c_ST_BUSY;
                        r_main_q <= in_data;
                    end
                end
                c_ST_BUSY: begin
                    if (w_acc_in && w_acc_out) begin
                        r_main_q <= in_data;
                    end else if (w_acc_in) begin
                        r_state  <= c_ST_FULL;
                        r_skid_q <= in_data;
                    end else if (w_acc_out) begin
                        r_state <= c_ST_EMPTY;
                    end
                end
                c_ST_FULL: begin
                    if (w_acc_out) begin
                        r_state  <= c_ST_BUSY;
                        r_main_q <= r_skid_q;
                    end
                end
                default: begin
                    r_state <= c_ST_EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_stall_inc = out_valid & ~out_ready;
    assign w_flush_inc = flush & (r_state != c_ST_EMPTY);

    sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stall_inc),
        .cnt   (stat_stall_cnt)
    );

    sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_flush_inc),
        .cnt   (stat_flush_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ============================================================================
//  Module      : tb_pipe_stage_skid
//  Description : Self-checking bench for pipe_stage_skid: queue reference
//                model plus directed literal checks; stats under
//                PIPE_STAGE_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_skid;

    localparam int PAYLOAD_W = 46;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [PAYLOAD_W-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [PAYLOAD_W-1:0] out_data;
`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0]     stat_stall_cnt;
    logic [CNT_W-1:0]     stat_flush_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    pipe_stage_skid #(
        .PAYLOAD_W (PAYLOAD_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stat_stall_cnt (stat_stall_cnt),
        .stat_flush_cnt (stat_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of depth 2 whose ready is "not full".
    logic [PAYLOAD_W-1:0] mq[$];
    int m_stall = 0;
    int m_flush = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            int  n;
            bit  ao;
            bit  ai;
            n  = mq.size();
            ao = (n > 0) && out_ready;
            ai = in_valid && (n < 2);
            if (n > 0 && !out_ready && m_stall < CNT_MAX) m_stall++;
            if (flush && n > 0 && m_flush < CNT_MAX) m_flush++;
            if (flush) begin
                mq.delete();
            end else begin
                if (ao) void'(mq.pop_front());
                if (ai) mq.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
        chk("in_ready", {63'd0, in_ready}, {63'd0, mq.size() < 2});
        if (mq.size() > 0)
            chk("out_data", 64'(out_data), 64'(mq[0]));
`ifdef PIPE_STAGE_STATS_EN
        chk("stat_stall_cnt", 64'(stat_stall_cnt), 64'(m_stall));
        chk("stat_flush_cnt", 64'(stat_flush_cnt), 64'(m_flush));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst out_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        step();

        // Streaming with downstream always ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = PAYLOAD_W'(i);
            step();
            chk("stream out_data", 64'(out_data), 64'(i));
            chk("stream in_ready", {63'd0, in_ready}, 64'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream drained", {63'd0, out_valid}, 64'd0);

        // Back-pressure fills the skid entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = PAYLOAD_W'(46'hA);
        step();
        chk("bp first out_data", 64'(out_data), 64'hA);
        in_data = PAYLOAD_W'(46'hB);
        step();
        chk("bp full in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp full out_data", 64'(out_data), 64'hA);
        in_data = PAYLOAD_W'(46'hD);
        step();
        chk("bp hold out_data", 64'(out_data), 64'hA);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp second out_data", 64'(out_data), 64'hB);
        chk("bp in_ready back", {63'd0, in_ready}, 64'd1);
        step();
        chk("bp drained", {63'd0, out_valid}, 64'd0);

        // Flush while full, with a simultaneous input offer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = PAYLOAD_W'(46'hA);
        step();
        in_data = PAYLOAD_W'(46'hB);
        step();
        flush   = 1'b1;
        in_data = PAYLOAD_W'(46'hC);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush in_ready", {63'd0, in_ready}, 64'd1);
`ifdef PIPE_STAGE_STATS_EN
        chk("flush stat cnt", 64'(stat_flush_cnt), 64'd1);
`endif
        out_ready = 1'b1;
        step();
        chk("flush no C", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset between clock edges while full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = PAYLOAD_W'(46'h11);
        step();
        in_data = PAYLOAD_W'(46'h22);
        step();
        in_valid = 1'b0;
        chk("pre-areset in_ready", {63'd0, in_ready}, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset out_valid", {63'd0, out_valid}, 64'd0);
        chk("areset in_ready", {63'd0, in_ready}, 64'd1);
        chk("areset out_data", 64'(out_data), 64'd0);
        step();
        rst_n = 1'b1;
        step();

`ifdef PIPE_STAGE_STATS_EN
        // Long stall saturates the stall counter
        in_valid  = 1'b1;
        in_data   = PAYLOAD_W'(46'h5);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("stall saturate", 64'(stat_stall_cnt), 64'hF);
        out_ready = 1'b1;
        step();
`endif

        // Random traffic against the queue model
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            in_data   = PAYLOAD_W'({$urandom, $urandom});
            step();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
